// File: rtl/instructions_pkg.sv
// Shared RV32 decode types: opcodes, format enum, decoded packet.
// Imported by instr_decoder and instr_decode_queue.
package instructions_pkg;

   localparam int PKG_XLEN = 32;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [3:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_FENCE,
      FMT_SYSTEM,
      FMT_ILLEGAL
   } instr_fmt_t;

   typedef struct packed {
      logic [PKG_XLEN-1:0] pc;
      logic [6:0]          opcode;
      instr_fmt_t          fmt;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [PKG_XLEN-1:0] imm;
      logic                rd_we;
      logic                illegal;
   } decoded_instr_t;

   function automatic logic [PKG_XLEN-1:0] sext32(
      input logic [31:0] v
   );
      return PKG_XLEN'($signed(v));
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32 decoder: one raw word + PC in, one packet out.
// Ports: i_instr (raw word), i_pc (its PC), o_pkt (decoded_instr_t).
module instr_decoder
   import instructions_pkg::*;
(
   input  logic [31:0]         i_instr,
   input  logic [PKG_XLEN-1:0] i_pc,
   output decoded_instr_t      o_pkt
);

   logic [31:0] w_imm32;
   instr_fmt_t  w_fmt;
   logic [31:0] w;

   assign w = i_instr;

   always_comb begin
      w_fmt   = FMT_ILLEGAL;
      w_imm32 = '0;
      case (w[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
            w_fmt   = FMT_I;
            w_imm32 = {{20{w[31]}}, w[31:20]};
         end
         OPC_STORE: begin
            w_fmt   = FMT_S;
            w_imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
         end
         OPC_BRANCH: begin
            w_fmt   = FMT_B;
            w_imm32 = {{19{w[31]}}, w[31], w[7],
                       w[30:25], w[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            w_fmt   = FMT_U;
            w_imm32 = {w[31:12], 12'b0};
         end
         OPC_JAL: begin
            w_fmt   = FMT_J;
            w_imm32 = {{11{w[31]}}, w[31], w[19:12],
                       w[20], w[30:21], 1'b0};
         end
         OPC_MISC_MEM: begin
            w_fmt   = FMT_FENCE;
            w_imm32 = {20'b0, w[31:20]};
         end
         OPC_SYSTEM: begin
            w_fmt   = FMT_SYSTEM;
            w_imm32 = {20'b0, w[31:20]};
         end
         OPC_OP: begin
            // only base ALU and SUB/SRA encodings; M-ext is not supported
            if (w[31:25] == 7'b0000000 ||
                w[31:25] == 7'b0100000)
               w_fmt = FMT_R;
         end
         default: w_fmt = FMT_ILLEGAL;
      endcase
      if (w[1:0] != 2'b11)
         w_fmt = FMT_ILLEGAL;
      if (w_fmt == FMT_ILLEGAL)
         w_imm32 = '0;
   end

   always_comb begin
      o_pkt         = '0;
      o_pkt.pc      = i_pc;
      o_pkt.opcode  = w[6:0];
      o_pkt.fmt     = w_fmt;
      o_pkt.rd      = w[11:7];
      o_pkt.rs1     = w[19:15];
      o_pkt.rs2     = w[24:20];
      o_pkt.funct3  = w[14:12];
      o_pkt.funct7  = w[31:25];
      o_pkt.imm     = sext32(w_imm32);
      o_pkt.illegal = (w_fmt == FMT_ILLEGAL);
      o_pkt.rd_we   = (w[11:7] != 5'd0) &&
                      (w_fmt inside {FMT_R, FMT_I, FMT_U,
                                     FMT_J, FMT_SYSTEM});
   end

endmodule

// File: rtl/instr_decode_queue.sv
// Decode-and-buffer stage: decodes up to FETCH_WIDTH words per cycle
// into a DEPTH-entry in-order queue, drained ISSUE_WIDTH per cycle.
// Ports: clk, rst_n, flush; in_valid/in_ready/in_count/in_instr/in_pc
// (fetch side); out_valid/out_pkt/out_take (issue side); occupancy.
module instr_decode_queue
   import instructions_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2,
   parameter int DEPTH       = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [$clog2(FETCH_WIDTH):0]      in_count,
   input  logic [FETCH_WIDTH*32-1:0]         in_instr,
   input  logic [FETCH_WIDTH*XLEN-1:0]       in_pc,
   output logic [ISSUE_WIDTH-1:0]            out_valid,
   output logic [ISSUE_WIDTH*$bits(decoded_instr_t)-1:0] out_pkt,
   input  logic [$clog2(ISSUE_WIDTH):0]      out_take,
   output logic [$clog2(DEPTH):0]            occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam int CW = $clog2(FETCH_WIDTH) + 1;
   localparam int TW = $clog2(ISSUE_WIDTH) + 1;
   localparam int PW = $bits(decoded_instr_t);

   decoded_instr_t  w_dec [FETCH_WIDTH];
   decoded_instr_t  r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [OW-1:0]   r_occ;
   logic [CW-1:0]   w_cnt;
   logic [CW-1:0]   w_pushed;
   logic            w_push;
   logic [TW-1:0]   w_nvalid;
   logic [TW-1:0]   w_take;

   for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_dec
      instr_decoder u_dec (
         .i_instr (in_instr[g*32 +: 32]),
         .i_pc    (in_pc[g*XLEN +: XLEN]),
         .o_pkt   (w_dec[g])
      );
   end

   // only registered occupancy feeds ready: no path from out_take
   assign in_ready  = (OW'(DEPTH) - r_occ) >= OW'(FETCH_WIDTH);
   assign occupancy = r_occ;

   always_comb begin
      w_cnt = (in_count > CW'(FETCH_WIDTH)) ?
              CW'(FETCH_WIDTH) : in_count;
      w_push = in_valid && in_ready &&
               (w_cnt != '0) && !flush;
      w_pushed = w_push ? w_cnt : '0;
      w_nvalid = (r_occ >= OW'(ISSUE_WIDTH)) ?
                 TW'(ISSUE_WIDTH) : TW'(r_occ);
      // over-asks are clamped to what is actually presented
      w_take = (out_take > w_nvalid) ? w_nvalid : out_take;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_pushed);
         r_rd_ptr <= r_rd_ptr + AW'(w_take);
         r_occ    <= r_occ + OW'(w_pushed) - OW'(w_take);
      end
   end

   // payload needs no reset: lanes are masked by out_valid
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (w_push && (i < int'(w_cnt)))
            r_mem[r_wr_ptr + AW'(i)] <= w_dec[i];
      end
   end

   always_comb begin
      out_valid = '0;
      out_pkt   = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         out_valid[i] = r_occ > OW'(i);
         if (out_valid[i])
            out_pkt[i*PW +: PW] = r_mem[r_rd_ptr + AW'(i)];
      end
   end

   a_in_count : assert property (
      @(posedge clk) disable iff (!rst_n)
      in_valid |-> (in_count <= CW'(FETCH_WIDTH)));

   a_take : assert property (
      @(posedge clk) disable iff (!rst_n)
      (r_occ != '0) |-> (out_take <= w_nvalid));

endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: directed pushes feed a scoreboard,
// a negedge monitor pops and compares every packet taken.
module tb_instr_decode_queue;
   import instructions_pkg::*;

   localparam int FW    = 2;
   localparam int IW    = 2;
   localparam int DEPTH = 8;
   localparam int PW    = $bits(decoded_instr_t);

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [1:0]      in_count = '0;
   logic [63:0]     in_instr = '0;
   logic [63:0]     in_pc = '0;
   logic [1:0]      out_valid;
   logic [IW*PW-1:0] out_pkt;
   logic [1:0]      out_take = '0;
   logic [3:0]      occupancy;

   typedef struct {
      logic [31:0] pc;
      instr_fmt_t  fmt;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        we;
      logic        ill;
   } exp_t;

   exp_t           sb[$];
   int             n_checks = 0;
   int             n_errors = 0;
   int             m_occ = 0;
   logic [31:0]    next_pc = 32'h100;
   int             fk = 0;
   exp_t           e_nil;
   decoded_instr_t p_mon;
   exp_t           e_mon;

   instr_decode_queue #(
      .XLEN(32), .FETCH_WIDTH(FW),
      .ISSUE_WIDTH(IW), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_count(in_count), .in_instr(in_instr),
      .in_pc(in_pc), .out_valid(out_valid),
      .out_pkt(out_pkt), .out_take(out_take),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h",
                  nm, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc,
                               input instr_fmt_t f,
                               input logic [4:0] rd,
                               input logic [31:0] imm,
                               input logic we,
                               input logic ill);
      exp_t e;
      e.pc = pc; e.fmt = f; e.rd = rd;
      e.imm = imm; e.we = we; e.ill = ill;
      return e;
   endfunction

   // filler: addi x1,x0,5 and lui x1,0x12345 alternately
   function automatic logic [31:0] fw(input int k);
      return (k % 2 == 0) ? 32'h00500093 : 32'h123450B7;
   endfunction

   function automatic exp_t fe(input int k,
                               input logic [31:0] pc);
      if (k % 2 == 0)
         return mk(pc, FMT_I, 5'd1, 32'd5, 1'b1, 1'b0);
      return mk(pc, FMT_U, 5'd1, 32'h12345000, 1'b1, 1'b0);
   endfunction

   always @(negedge clk) begin
      if (rst_n && !flush) begin
         for (int i = 0; i < IW; i++) begin
            if (i < int'(out_take)) begin
               chk("taken_valid", 64'(out_valid[i]), 64'd1);
               p_mon = out_pkt[i*PW +: PW];
               if (sb.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL sb_underflow: got pc %0h, expected none",
                           p_mon.pc);
               end else begin
                  e_mon = sb.pop_front();
                  chk("pc", 64'(p_mon.pc), 64'(e_mon.pc));
                  chk("fmt", 64'(p_mon.fmt), 64'(e_mon.fmt));
                  chk("rd", 64'(p_mon.rd), 64'(e_mon.rd));
                  chk("imm", 64'(p_mon.imm), 64'(e_mon.imm));
                  chk("rd_we", 64'(p_mon.rd_we), 64'(e_mon.we));
                  chk("illegal", 64'(p_mon.illegal),
                      64'(e_mon.ill));
               end
            end
         end
      end
   end

   task automatic cyc(input logic v, input int n,
                      input logic [31:0] w0, input logic [31:0] w1,
                      input exp_t e0, input exp_t e1,
                      input int take_req, input logic fl);
      int take;
      int pushed;
      take = take_req;
      if (take > m_occ) take = m_occ;
      if (take > IW) take = IW;
      in_valid = v;
      in_count = n[1:0];
      in_instr = {w1, w0};
      in_pc    = {e1.pc, e0.pc};
      out_take = take[1:0];
      flush    = fl;
      pushed = (v && n != 0 && (DEPTH - m_occ) >= FW) ? n : 0;
      if (!fl) begin
         if (pushed > 0) sb.push_back(e0);
         if (pushed > 1) sb.push_back(e1);
      end
      @(posedge clk);
      #1;
      if (fl) begin
         sb.delete();
         m_occ = 0;
      end else begin
         m_occ = m_occ + pushed - take;
      end
      in_valid = 1'b0;
      in_count = '0;
      out_take = '0;
      flush    = 1'b0;
      chk("occupancy", 64'(occupancy), 64'(m_occ));
      chk("in_ready", 64'(in_ready),
          64'((DEPTH - m_occ) >= FW));
      for (int i = 0; i < IW; i++) begin
         chk("out_valid", 64'(out_valid[i]), 64'(m_occ > i));
         if (m_occ <= i)
            chk("lane_zero",
                64'(out_pkt[i*PW +: PW] !== '0), 64'd0);
      end
   endtask

   task automatic pushfill(input int n, input int take);
      logic acc;
      acc = (DEPTH - m_occ) >= FW;
      cyc(1'b1, n, fw(fk), fw(fk + 1),
          fe(fk, next_pc), fe(fk + 1, next_pc + 32'd4),
          take, 1'b0);
      if (acc) begin
         next_pc = next_pc + 32'(4 * n);
         fk = fk + n;
      end
   endtask

   task automatic idle(input int take);
      cyc(1'b0, 0, '0, '0, e_nil, e_nil, take, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      e_nil = mk('0, FMT_R, '0, '0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_pkt", 64'(out_pkt !== '0), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // addi + beq pair
      cyc(1'b1, 2, 32'h00500093, 32'hFE000EE3,
          mk(32'h100, FMT_I, 5'd1, 32'd5, 1'b1, 1'b0),
          mk(32'h104, FMT_B, 5'd29, 32'hFFFFFFFC, 1'b0, 1'b0),
          0, 1'b0);
      chk("first_valid", 64'(out_valid), 64'h3);
      idle(2);
      next_pc = 32'h200;

      // fill to full, stalled 5th push, pop frees space
      repeat (4) pushfill(2, 0);
      chk("full_occ", 64'(occupancy), 64'd8);
      pushfill(2, 0);
      idle(2);
      chk("ready_back", 64'(in_ready), 64'd1);
      repeat (3) idle(2);

      // wrap-around, sustained push with single pops
      repeat (20) pushfill(2, 1);
      while (m_occ > 0) idle(2);

      // illegal and assorted formats
      cyc(1'b1, 2, 32'h00000000, 32'h0000007F,
          mk(32'h400, FMT_ILLEGAL, 5'd0, 32'd0, 1'b0, 1'b1),
          mk(32'h404, FMT_ILLEGAL, 5'd0, 32'd0, 1'b0, 1'b1),
          0, 1'b0);
      cyc(1'b1, 2, 32'hFE51AC23, 32'h008000EF,
          mk(32'h408, FMT_S, 5'd24, 32'hFFFFFFF8, 1'b0, 1'b0),
          mk(32'h40C, FMT_J, 5'd1, 32'd8, 1'b1, 1'b0),
          2, 1'b0);
      cyc(1'b1, 2, 32'h402081B3, 32'h022081B3,
          mk(32'h410, FMT_R, 5'd3, 32'd0, 1'b1, 1'b0),
          mk(32'h414, FMT_ILLEGAL, 5'd3, 32'd0, 1'b0, 1'b1),
          2, 1'b0);
      cyc(1'b1, 2, 32'hC00022F3, 32'h0FF0000F,
          mk(32'h418, FMT_SYSTEM, 5'd5, 32'hC00, 1'b1, 1'b0),
          mk(32'h41C, FMT_FENCE, 5'd0, 32'hFF, 1'b0, 1'b0),
          2, 1'b0);
      cyc(1'b1, 1, 32'h00000073, 32'h0,
          mk(32'h420, FMT_SYSTEM, 5'd0, 32'd0, 1'b0, 1'b0),
          e_nil, 2, 1'b0);
      idle(1);

      // flush beats same-cycle push and pop
      pushfill(2, 0);
      cyc(1'b1, 2, 32'h00500093, 32'h00500093,
          mk(32'hF000, FMT_I, 5'd1, 32'd5, 1'b1, 1'b0),
          mk(32'hF004, FMT_I, 5'd1, 32'd5, 1'b1, 1'b0),
          1, 1'b1);
      chk("flush_occ", 64'(occupancy), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      pushfill(2, 0);
      idle(2);

      // asynchronous reset with 5 entries queued
      pushfill(2, 0);
      pushfill(2, 0);
      pushfill(1, 0);
      chk("pre_rst_occ", 64'(occupancy), 64'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_ready", 64'(in_ready), 64'd1);
      chk("arst_occ", 64'(occupancy), 64'd0);
      sb.delete();
      m_occ = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      pushfill(2, 0);
      idle(2);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
